// File: rtl/instr_encoder_if.sv
// Request/response bundle between the program-load source and the RV32I encoder,
// and between the encoder and the instruction-memory writer.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_format;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  in_flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;
  logic                  addr_wrap;

  modport master (
    output in_valid, in_format, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_flush, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, addr_wrap
  );

  modport slave (
    input  in_valid, in_format, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_flush, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, addr_wrap
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction fields into RV32I words, tags them with a sequential word
// address and a range-error flag, and queues them in a 2-entry output buffer.
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic           clk,
  input  logic           rstn,
  instr_encoder_if.slave bus
);

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  err;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  entry_t                slot_q [2];
  entry_t                slot_d [2];
  logic [1:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wrap_q, wrap_d;

  logic        [31:0] enc_word;
  logic               enc_err;
  logic signed [31:0] imm_s;
  logic               is_shift;
  logic               push, pop;
  logic [1:0]         wr_idx;

  assign imm_s    = $signed(bus.in_imm);
  assign is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (bus.in_format)
      3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
      3'd1: begin
        if (is_shift) begin
          enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                      bus.in_rd, bus.in_opcode};
          enc_err  = (imm_s < 0) || (imm_s > 32'sd31);
        end else begin
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                      bus.in_rd, bus.in_opcode};
          enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        end
      end
      3'd2: begin
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:0], bus.in_opcode};
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      3'd3: begin
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                    bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
        enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
      end
      3'd4: begin
        enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
        enc_err  = (bus.in_imm[11:0] != 12'd0);
      end
      3'd5: begin
        enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                    bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.in_imm[0];
      end
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = slot_q[0].instr;
  assign bus.out_addr  = slot_q[0].addr;
  assign bus.out_err   = slot_q[0].err;
  assign bus.addr_wrap = wrap_q;

  assign push   = bus.in_valid && bus.in_ready && !bus.in_flush;
  assign pop    = bus.out_valid && bus.out_ready && !bus.in_flush;
  assign wr_idx = pop ? (count_q - 2'd1) : count_q;

  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    count_d   = count_q;
    addr_d    = addr_q;
    wrap_d    = wrap_q;
    if (bus.in_flush) begin
      count_d = 2'd0;
      addr_d  = BASE_ADDR;
      wrap_d  = 1'b0;
    end else begin
      if (pop) begin
        slot_d[0] = slot_q[1];
        count_d   = count_q - 2'd1;
      end
      if (push) begin
        slot_d[wr_idx[0]] = '{instr: enc_word, addr: addr_q, err: enc_err};
        count_d           = wr_idx + 2'd1;
        addr_d            = addr_q + 1'b1;
        if (addr_q == '1) wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
      addr_q    <= BASE_ADDR;
      wrap_q    <= 1'b0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      count_q   <= count_d;
      addr_q    <= addr_d;
      wrap_q    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, range errors, backpressure,
// randomized traffic against a field-arithmetic model, and address wrap on a narrow instance.
module tb_instr_encoder;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   next_addr;

  instr_encoder_if #(.ADDR_WIDTH(10)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(2))  bus2 ();

  instr_encoder #(.ADDR_WIDTH(10)) u_dut  (.clk(clk), .rstn(rstn), .bus(bus));
  instr_encoder #(.ADDR_WIDTH(2))  u_dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int          addr;
    logic        e;
  } exp_t;

  // Reference encoder built from field weights (multiply/divide), not bit slicing.
  function automatic void ref_encode(input int unsigned fmt, op, f3, f7, rd, rs1, rs2,
                                     input int imm, output logic [31:0] w, output logic e);
    int unsigned u = imm;
    int unsigned r;
    r = 0;
    e = 1'b0;
    case (fmt)
      0: r = op + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 33554432;
      1: begin
        if (f3 == 1 || f3 == 5) begin
          r = op + rd * 128 + f3 * 4096 + rs1 * 32768 + (u % 32) * 1048576 + f7 * 33554432;
          e = (imm < 0) || (imm > 31);
        end else begin
          r = op + rd * 128 + f3 * 4096 + rs1 * 32768 + (u % 4096) * 1048576;
          e = (imm < -2048) || (imm > 2047);
        end
      end
      2: begin
        r = op + (u % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
            + ((u / 32) % 128) * 33554432;
        e = (imm < -2048) || (imm > 2047);
      end
      3: begin
        r = op + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256 + f3 * 4096 + rs1 * 32768
            + rs2 * 1048576 + ((u / 32) % 64) * 33554432 + ((u / 4096) % 2) * 32'h8000_0000;
        e = (imm < -4096) || (imm > 4094) || (u % 2 != 0);
      end
      4: begin
        r = op + rd * 128 + (u / 4096) * 4096;
        e = (u % 4096) != 0;
      end
      5: begin
        r = op + rd * 128 + ((u / 4096) % 256) * 4096 + ((u / 2048) % 2) * 1048576
            + ((u / 2) % 1024) * 2097152 + ((u / 1048576) % 2) * 32'h8000_0000;
        e = (imm < -1048576) || (imm > 1048574) || (u % 2 != 0);
      end
      default: begin
        r = 32'h13;
        e = 1'b1;
      end
    endcase
    w = r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned fmt, op, f3, f7, rd, rs1, rs2, input int imm);
    bus.in_format = 3'(fmt);
    bus.in_opcode = 7'(op);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_imm    = imm;
  endtask

  task automatic do_flush();
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    next_addr    = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== 10'h0 ||
        bus.out_err !== 1'b0 || bus.addr_wrap !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b instr=%h addr=%0d err=%b wrap=%b rdy=%b, want 0 0 0 0 0 1",
               bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.addr_wrap, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    int unsigned fmt_t[5] = '{1, 0, 3, 5, 4};
    int unsigned op_t[5]  = '{'h13, 'h33, 'h63, 'h6F, 'h37};
    int unsigned f7_t[5]  = '{0, 'h20, 0, 0, 0};
    int unsigned rd_t[5]  = '{1, 3, 0, 1, 5};
    int unsigned rs1_t[5] = '{0, 1, 0, 0, 0};
    int unsigned rs2_t[5] = '{0, 2, 0, 0, 0};
    int          imm_t[5] = '{5, 0, -4, 'h800, 'h1234_5000};
    logic [31:0] exp_t5[5] = '{32'h00500093, 32'h402081B3, 32'hFE000EE3, 32'h001000EF, 32'h123452B7};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(fmt_t[i], op_t[i], 0, f7_t[i], rd_t[i], rs1_t[i], rs2_t[i], imm_t[i]);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_t5[i] ||
          bus.out_addr !== 10'(next_addr) || bus.out_err !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d: got v=%b instr=%h addr=%0d err=%b, want v=1 instr=%h addr=%0d err=0",
                 i, bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, exp_t5[i], next_addr);
      end
      next_addr++;
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_drain_%0d: got out_valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_errors();
    int unsigned fmt_t[15] = '{1, 1, 1, 3, 3, 3, 3, 4, 5, 5, 5, 1, 1, 2, 7};
    int unsigned f3_t[15]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 2, 0};
    int          imm_t[15] = '{2048, -2048, 2047, 3, 4094, -4096, 4096, 'h1001,
                               1048574, -1048576, 1048576, 31, 32, -2049, 0};
    logic        err_t[15] = '{1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1};
    logic [31:0] w;
    logic        e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_req(fmt_t[i], 'h13 + i, f3_t[i], 0, 2, 3, 4, imm_t[i]);
      ref_encode(fmt_t[i], 'h13 + i, f3_t[i], 0, 2, 3, 4, imm_t[i], w, e);
      if (fmt_t[i] == 7) w = 32'h0000_0013;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_err !== err_t[i] || bus.out_instr !== w ||
          bus.out_addr !== 10'(next_addr)) begin
        errors++;
        $display("FAIL err_case_%0d: got v=%b err=%b instr=%h addr=%0d, want v=1 err=%b instr=%h addr=%0d",
                 i, bus.out_valid, bus.out_err, bus.out_instr, bus.out_addr, err_t[i], w, next_addr);
      end
      next_addr++;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    logic        e;
    logic        acc;
    int          n;
    do_flush();
    for (int i = 0; i < 3; i++) ref_encode(1, 'h13, 0, 0, i + 1, i, 0, i * 3, w[i], e);
    bus.out_ready = 1'b0;
    set_req(1, 'h13, 0, 0, 1, 0, 0, 0);
    bus.in_valid = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_1: got %b want 1", bus.in_ready);
    end
    set_req(1, 'h13, 0, 0, 2, 1, 0, 3);
    step();
    set_req(1, 'h13, 0, 0, 3, 2, 0, 6);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== w[0] ||
          bus.out_addr !== 10'd0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b instr=%h addr=%0d, want rdy=0 v=1 instr=%h addr=0",
                 c, bus.in_ready, bus.out_valid, bus.out_instr, bus.out_addr, w[0]);
      end
      step();
    end
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_instr !== w[n] || bus.out_addr !== 10'(n)) begin
          errors++;
          $display("FAIL bp_drain_%0d: got instr=%h addr=%0d, want instr=%h addr=%0d",
                   n, bus.out_instr, bus.out_addr, w[n], n);
        end
        n++;
      end
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL bp_timeout: drained %0d words want 3", n);
    end
    next_addr = 3;
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        x;
    int          model_addr;
    int unsigned fmt, op, f3, f7, rd, rs1, rs2;
    int          imm;
    logic        can_push;
    do_flush();
    model_addr = 0;
    for (int c = 0; c < 800; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      fmt = $urandom_range(0, 7);
      op  = $urandom_range(0, 127);
      f3  = $urandom_range(0, 7);
      f7  = $urandom_range(0, 127);
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = int'($urandom_range(0, 8191)) - 4096;
        2: imm = (int'($urandom_range(0, 4194303)) - 2097152) & ~1;
        3: imm = $urandom & 32'hFFFF_F000;
        default: imm = $urandom_range(0, 40);
      endcase
      set_req(fmt, op, f3, f7, rd, rs1, rs2, imm);
      checks++;
      if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rand_flags_c%0d: got v=%b rdy=%b, model depth %0d", c,
                 bus.out_valid, bus.in_ready, q.size());
      end
      can_push = (q.size() < 2) && bus.in_valid;
      if (q.size() != 0 && bus.out_ready) begin
        x = q.pop_front();
        checks++;
        if (bus.out_instr !== x.w || bus.out_addr !== 10'(x.addr) || bus.out_err !== x.e) begin
          errors++;
          $display("FAIL rand_pop_c%0d: got instr=%h addr=%0d err=%b, want instr=%h addr=%0d err=%b",
                   c, bus.out_instr, bus.out_addr, bus.out_err, x.w, x.addr, x.e);
        end
      end
      if (can_push) begin
        ref_encode(fmt, op, f3, f7, rd, rs1, rs2, imm, x.w, x.e);
        x.addr = model_addr;
        q.push_back(x);
        model_addr = (model_addr + 1) % 1024;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_wrap_flush();
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus2.in_valid = 1'b0;
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.out_addr !== 2'(i % 4)) begin
        errors++;
        $display("FAIL wrap_addr_%0d: got v=%b addr=%0d, want v=1 addr=%0d",
                 i, bus2.out_valid, bus2.out_addr, i % 4);
      end
      step();
    end
    checks++;
    if (bus2.addr_wrap !== 1'b1 || bus2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sticky: got wrap=%b v=%b, want wrap=1 v=0", bus2.addr_wrap, bus2.out_valid);
    end
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    step();
    bus2.in_flush = 1'b1;
    step();
    bus2.in_flush = 1'b0;
    bus2.in_valid = 1'b0;
    checks++;
    if (bus2.out_valid !== 1'b0 || bus2.addr_wrap !== 1'b0 || bus2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got v=%b wrap=%b rdy=%b, want 0 0 1",
               bus2.out_valid, bus2.addr_wrap, bus2.in_ready);
    end
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    checks++;
    if (bus2.out_valid !== 1'b1 || bus2.out_addr !== 2'd0) begin
      errors++;
      $display("FAIL flush_next_addr: got v=%b addr=%0d, want v=1 addr=0", bus2.out_valid, bus2.out_addr);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.in_imm    = 32'd100;
    step();
    step();
    bus2.in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus2.out_valid !== 1'b0 || bus2.out_instr !== 32'h0 || bus2.out_addr !== 2'd0 ||
        bus2.out_err !== 1'b0 || bus2.addr_wrap !== 1'b0 || bus2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b instr=%h addr=%0d err=%b wrap=%b rdy=%b, want 0 0 0 0 0 1",
               bus2.out_valid, bus2.out_instr, bus2.out_addr, bus2.out_err, bus2.addr_wrap, bus2.in_ready);
    end
    #3 rstn = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    next_addr = 0;
    rstn = 1'b0;
    bus.in_valid = 1'b0;  bus.in_flush = 1'b0;  bus.out_ready = 1'b0;
    bus.in_format = 3'd0; bus.in_opcode = 7'd0; bus.in_funct3 = 3'd0; bus.in_funct7 = 7'd0;
    bus.in_rd = 5'd0;     bus.in_rs1 = 5'd0;    bus.in_rs2 = 5'd0;    bus.in_imm = 32'd0;
    bus2.in_valid = 1'b0; bus2.in_flush = 1'b0; bus2.out_ready = 1'b0;
    bus2.in_format = 3'd1; bus2.in_opcode = 7'h13; bus2.in_funct3 = 3'd0; bus2.in_funct7 = 7'd0;
    bus2.in_rd = 5'd1;    bus2.in_rs1 = 5'd0;   bus2.in_rs2 = 5'd0;   bus2.in_imm = 32'd1;
    #12 rstn = 1'b1;
    step();
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_random();
    test_wrap_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
